// File: rtl/inst_rom_loader_pkg.sv
// Shared definitions for the instruction ROM loader: load FSM encodings and bus widths.
package inst_rom_loader_pkg;

   localparam int RegBusW      = 16;
   localparam int InstAddrBusW = 16;
   localparam int LoadByteW    = 8;
   localparam int CountW       = 16;

   typedef enum logic [2:0] {
      LoadStLenHi  = 3'd0,
      LoadStLenLo  = 3'd1,
      LoadStDataHi = 3'd2,
      LoadStDataLo = 3'd3,
      LoadStRun    = 3'd4
   } loadState_t;

endpackage

// File: rtl/inst_rom_loader_ram.sv
// Instruction RAM: one synchronous write port for the boot loader and one
// asynchronous read port so fetches complete in the same cycle as the PC.
module inst_rom_loader_ram
   import inst_rom_loader_pkg::*;
#(
   parameter int DATA_W     = RegBusW,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  wrEn,
   input  logic [DEPTH_LOG2-1:0] wrAddr,
   input  logic [DATA_W-1:0]     wrData,
   input  logic [DEPTH_LOG2-1:0] rdAddr,
   output logic [DATA_W-1:0]     rdData
);

   logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (wrEn) begin
         mem[wrAddr] <= wrData;
      end
   end

   assign rdData = mem[rdAddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Boot-loads the program from a length-prefixed byte stream into the instruction
// RAM, then serves zero-latency CPU fetches with range checking.
module inst_rom_loader
   import inst_rom_loader_pkg::*;
#(
   parameter int DATA_W     = RegBusW,
   parameter int ADDR_W     = InstAddrBusW,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 romEnable_i,
   input  logic [ADDR_W-1:0]    romAddr_i,
   output logic [DATA_W-1:0]    romData_o,
   output logic                 romReady_o,
   output logic                 romErr_o,
   input  logic                 loadValid_i,
   input  logic [LoadByteW-1:0] loadData_i,
   output logic                 loadReady_o
);

   localparam int Depth = 1 << DEPTH_LOG2;
   // One bit wider than the count so the pointer never wraps before the last word.
   localparam int PtrW  = CountW + 1;

   loadState_t state, stateNext;

   logic [CountW-1:0]    wordCount;
   logic [PtrW-1:0]      wrPtr;
   logic [LoadByteW-1:0] hiByte;
   logic                 romErr;
   logic                 byteAccept;
   logic                 ramWe;
   logic                 ptrInRange;
   logic                 lastWord;
   logic                 fetchHit;
   logic                 fetchMiss;
   logic [31:0]          addrExt;
   logic [31:0]          limitExt;
   logic [DATA_W-1:0]    ramRdData;

   // Readable words are bounded by both the loaded count and the physical depth.
   function automatic logic [PtrW-1:0] satLimit(input logic [CountW-1:0] n);
      logic [PtrW-1:0] nExt;
      nExt = {1'b0, n};
      satLimit = (nExt > PtrW'(Depth)) ? PtrW'(Depth) : nExt;
   endfunction

   assign byteAccept = loadValid_i && loadReady_o;
   assign ptrInRange = (wrPtr < PtrW'(Depth));
   assign lastWord   = ((wrPtr + PtrW'(1)) == {1'b0, wordCount});
   assign addrExt    = 32'(romAddr_i);
   assign limitExt   = 32'(satLimit(wordCount));
   assign romErr_o   = romErr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= LoadStLenHi;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         LoadStLenHi: begin
            if (loadValid_i) stateNext = LoadStLenLo;
         end
         LoadStLenLo: begin
            if (loadValid_i) begin
               stateNext = ({wordCount[15:8], loadData_i} == '0) ? LoadStRun : LoadStDataHi;
            end
         end
         LoadStDataHi: begin
            if (loadValid_i) stateNext = LoadStDataLo;
         end
         LoadStDataLo: begin
            if (loadValid_i) stateNext = lastWord ? LoadStRun : LoadStDataHi;
         end
         LoadStRun:    stateNext = LoadStRun;
         default:      stateNext = LoadStLenHi;
      endcase
   end

   always_comb begin
      loadReady_o = (state != LoadStRun);
      romReady_o  = (state == LoadStRun);
      ramWe       = (state == LoadStDataLo) && loadValid_i && ptrInRange;
      fetchHit    = (state == LoadStRun) && romEnable_i && (addrExt < limitExt);
      fetchMiss   = (state == LoadStRun) && romEnable_i && (addrExt >= limitExt);
      romData_o   = fetchHit ? ramRdData : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wordCount <= '0;
         wrPtr     <= '0;
         romErr    <= 1'b0;
      end else begin
         if (byteAccept && (state == LoadStLenHi)) wordCount[15:8] <= loadData_i;
         if (byteAccept && (state == LoadStLenLo)) wordCount[7:0]  <= loadData_i;
         if (byteAccept && (state == LoadStDataLo)) begin
            wrPtr <= wrPtr + PtrW'(1);
            if (!ptrInRange) romErr <= 1'b1;
         end
         if (fetchMiss) romErr <= 1'b1;
      end
   end

   // High byte of the word in flight is pure data; a reset just orphans it.
   always_ff @(posedge clk) begin
      if (byteAccept && (state == LoadStDataHi)) hiByte <= loadData_i;
   end

   inst_rom_loader_ram #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) instRam (
      .clk    (clk),
      .wrEn   (ramWe),
      .wrAddr (wrPtr[DEPTH_LOG2-1:0]),
      .wrData (DATA_W'({hiByte, loadData_i})),
      .rdAddr (romAddr_i[DEPTH_LOG2-1:0]),
      .rdData (ramRdData)
   );

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed and randomized bench for inst_rom_loader against a word-image reference model.
module tb_inst_rom_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        romEnable = 1'b0;
   logic [15:0] romAddr = '0;
   logic [15:0] romData;
   logic        romReady;
   logic        romErr;
   logic        loadValid = 1'b0;
   logic [7:0]  loadData = '0;
   logic        loadReady;

   int vectors = 0;
   int miscompares = 0;

   logic [15:0] progWords[$];
   int          modelN = 0;
   bit          modelRun = 0;
   bit          modelErr = 0;

   always #5 clk = ~clk;

   inst_rom_loader #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10)) dut (
      .clk         (clk),
      .rst         (rst),
      .romEnable_i (romEnable),
      .romAddr_i   (romAddr),
      .romData_o   (romData),
      .romReady_o  (romReady),
      .romErr_o    (romErr),
      .loadValid_i (loadValid),
      .loadData_i  (loadData),
      .loadReady_o (loadReady)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int readLimit();
      return (modelN < 1024) ? modelN : 1024;
   endfunction

   function automatic logic [15:0] expFetch(input int addr, input bit en);
      if (modelRun && en && addr < readLimit()) return progWords[addr];
      return 16'h0000;
   endfunction

   task automatic doReset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      modelRun = 0;
      modelErr = 0;
      modelN = 0;
   endtask

   task automatic sendByte(input logic [7:0] b, input int maxGap);
      int gaps;
      gaps = (maxGap > 0) ? $urandom_range(0, maxGap) : 0;
      repeat (gaps) begin
         loadValid = 1'b0;
         @(negedge clk);
      end
      loadValid = 1'b1;
      loadData = b;
      @(negedge clk);
      loadValid = 1'b0;
   endtask

   // Streams count + progWords, checking ready flags around the final byte.
   task automatic loadProgram(input int n, input int maxGap, input string tag);
      logic [15:0] nv;
      nv = 16'(n);
      sendByte(nv[15:8], maxGap);
      if (n == 0) check({tag, "_readyPre"}, romReady, 1'b0);
      sendByte(nv[7:0], maxGap);
      for (int i = 0; i < n; i++) begin
         logic [15:0] w;
         w = progWords[i];
         sendByte(w[15:8], maxGap);
         if (i == n - 1) check({tag, "_readyPre"}, romReady, 1'b0);
         sendByte(w[7:0], maxGap);
      end
      modelN = n;
      modelRun = 1;
      if (n > 1024) modelErr = 1;
      check({tag, "_ready"}, romReady, 1'b1);
      check({tag, "_loadReady"}, loadReady, 1'b0);
   endtask

   task automatic checkFetch(input int addr, input bit en, input string tag);
      romEnable = en;
      romAddr = 16'(addr);
      #1;
      check({tag, "_data"}, romData, expFetch(addr, en));
      if (modelRun && en && addr >= readLimit()) modelErr = 1;
      @(negedge clk);
      check({tag, "_err"}, romErr, modelErr);
      romEnable = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      doReset();
      check("rst_ready", romReady, 1'b0);
      check("rst_err", romErr, 1'b0);
      check("rst_loadReady", loadReady, 1'b1);
      checkFetch(0, 1'b1, "rst_fetch");

      // N=3 directed program, with a fetch attempted mid-load
      progWords = '{16'h1234, 16'hABCD, 16'h0001};
      sendByte(8'h00, 0);
      sendByte(8'h03, 0);
      sendByte(8'h12, 0);
      sendByte(8'h34, 0);
      checkFetch(0, 1'b1, "midload_fetch");
      sendByte(8'hAB, 0);
      sendByte(8'hCD, 0);
      sendByte(8'h00, 0);
      check("n3_readyPre", romReady, 1'b0);
      sendByte(8'h01, 0);
      modelN = 3;
      modelRun = 1;
      check("n3_ready", romReady, 1'b1);
      check("n3_loadReady", loadReady, 1'b0);
      checkFetch(0, 1'b1, "n3_a0");
      checkFetch(1, 1'b1, "n3_a1");
      checkFetch(2, 1'b1, "n3_a2");
      checkFetch(1, 1'b0, "n3_noEn");
      sendByte(8'h55, 0);
      check("n3_runIgnore_ready", romReady, 1'b1);
      checkFetch(2, 1'b1, "n3_a2_again");
      checkFetch(3, 1'b1, "n3_oob");
      checkFetch(0, 1'b1, "n3_sticky");

      // N=0: straight to RUN, every fetch is out of range
      doReset();
      progWords.delete();
      loadProgram(0, 0, "n0");
      check("n0_errPre", romErr, 1'b0);
      checkFetch(0, 1'b1, "n0_a0");

      // N=4 random words with random valid gaps
      doReset();
      progWords.delete();
      for (int i = 0; i < 4; i++) progWords.push_back(16'($urandom));
      loadProgram(4, 3, "n4");
      for (int i = 0; i < 4; i++) checkFetch(i, 1'b1, $sformatf("n4_a%0d", i));
      check("n4_errClean", romErr, 1'b0);
      checkFetch(4, 1'b1, "n4_oob");

      // N=1026 overflows the 1024-word RAM
      doReset();
      progWords.delete();
      for (int i = 0; i < 1026; i++) progWords.push_back(16'($urandom));
      loadProgram(1026, 0, "ovf");
      check("ovf_err", romErr, 1'b1);
      checkFetch(1023, 1'b1, "ovf_a1023");
      checkFetch(0, 1'b1, "ovf_a0");
      for (int k = 0; k < 6; k++) begin
         int a;
         a = $urandom_range(0, 1023);
         checkFetch(a, 1'b1, $sformatf("ovf_rand%0d", a));
      end
      checkFetch(1024, 1'b1, "ovf_a1024");

      // Reset after 5 bytes of an N=3 stream, then a fresh N=1 load
      doReset();
      check("ovf_rstErr", romErr, 1'b0);
      sendByte(8'h00, 0);
      sendByte(8'h03, 0);
      sendByte(8'h11, 0);
      sendByte(8'h22, 0);
      sendByte(8'h33, 0);
      doReset();
      check("midrst_ready", romReady, 1'b0);
      check("midrst_loadReady", loadReady, 1'b1);
      progWords.delete();
      progWords.push_back(16'hBEEF);
      loadProgram(1, 2, "n1");
      check("n1_errPre", romErr, 1'b0);
      checkFetch(0, 1'b1, "n1_a0");
      checkFetch(1, 1'b1, "n1_a1");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
